series_job_sequencer: RTL and testbench
=======================================

SERIES_JOB_SEQUENCER -- requirements
Module: series_job_sequencer

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter START_LEN, default 2, meaning the number of cycles start is held high (legal 1..7).
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum wait cycles per wait state (legal 1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: an upstream operand is offered.
REQ-007 The block SHALL have port in_data, input, W bits: the upstream operand x.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the operand is accepted this cycle when in_ready and in_valid are both high.
REQ-009 The block SHALL have port start, output, 1 bit: start pulse to the series controller.
REQ-010 The block SHALL have port x_out, output, W bits: latched operand driven to the datapath.
REQ-011 The block SHALL have port dp_ready, input, 1 bit: the controller's ready flag (high when the controller is idle).
REQ-012 The block SHALL have port dp_result, input, W bits: the datapath result register.
REQ-013 The block SHALL have port out_valid, output, 1 bit: a result is offered downstream.
REQ-014 The block SHALL have port out_data, output, W bits: the captured result.
REQ-015 The block SHALL have port out_ready, input, 1 bit: downstream accepts; transfer occurs when out_valid and out_ready are both high.
REQ-016 The block SHALL have port err, output, 1 bit: sticky timeout flag.
REQ-017 The block SHALL have port jobs_done, output, 8 bits: count of completed result transfers.

Function
REQ-018 The block SHALL be a Moore FSM with states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE and HOLD; all outputs SHALL be registered or decoded from state only.
REQ-019 In IDLE, in_ready SHALL equal dp_ready; on acceptance, in_data SHALL be latched into x_out and the next state SHALL be LAUNCH.
REQ-020 In LAUNCH, start SHALL be 1 for exactly START_LEN consecutive cycles, then the FSM SHALL move to WAIT_BUSY; start SHALL be 0 in every other state.
REQ-021 In WAIT_BUSY, the FSM SHALL go to WAIT_DONE on the first cycle dp_ready=0.
REQ-022 In WAIT_DONE, on the first cycle dp_ready=1, dp_result SHALL be captured into out_data and the FSM SHALL go to HOLD.
REQ-023 In HOLD, out_valid SHALL be 1 and out_data SHALL be stable until transfer; on transfer, jobs_done SHALL increment by 1 (wrapping 255->0) and the FSM SHALL return to IDLE.
REQ-024 in_ready SHALL be 0 in every state other than IDLE; x_out SHALL change only on acceptance.
REQ-025 A wait counter SHALL clear on entry to WAIT_BUSY and to WAIT_DONE; if the counter reaches TIMEOUT while still waiting, err SHALL be set, out_valid SHALL NOT be asserted, and the FSM SHALL go to IDLE.
REQ-026 err SHALL be cleared only by reset; the block SHALL continue to accept jobs while err=1.
REQ-027 Back-to-back jobs SHALL be supported: a new acceptance SHALL be possible in the cycle after the HOLD transfer if dp_ready=1.
REQ-028 in_valid SHALL be ignored outside IDLE; no operand SHALL be dropped, since in_ready=0 there.

Reset
REQ-029 While rst_n=0, state SHALL be IDLE and start, out_valid, err, x_out, out_data and jobs_done SHALL all be 0; in_ready SHALL follow dp_ready.
REQ-030 Reset asserted mid-job SHALL abort immediately with no out_valid pulse; after release, the FSM SHALL resume in IDLE.

Verification
REQ-031 Single job: dp_ready=1, in_data=16'h0003 valid 1 cycle -> start high 2 cycles, x_out=3; model drops dp_ready for 5 cycles then raises it with dp_result=16'h0014 -> out_valid=1, out_data=16'h0014, jobs_done=1 after transfer.
REQ-032 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_valid stays 1, out_data stays constant, in_ready=0, jobs_done unchanged until out_ready=1.
REQ-033 Timeout: dp_ready stuck at 1 after launch -> err=1 after 255 wait cycles, no out_valid, FSM back in IDLE accepting the next job.
REQ-034 Wrap: 256 completed jobs -> jobs_done returns to 0.
REQ-035 Reset mid-WAIT_DONE: rst_n=0 for 1 cycle -> all outputs 0 immediately, no spurious out_valid; the next job completes normally.
REQ-036 Busy datapath: in_valid=1 with dp_ready=0 -> in_ready=0, no start issued until dp_ready=1.

Source files
------------

// File: rtl/series_job_sequencer.sv
// series_job_sequencer: accepts one operand, pulses start to a series controller, waits for it to finish and hands the result downstream.
module series_job_sequencer #(
  parameter int W         = 16,
  parameter int START_LEN = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         start,
  output logic [W-1:0] x_out,
  input  logic         dp_ready,
  input  logic [W-1:0] dp_result,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         err,
  output logic [7:0]   jobs_done
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, HOLD} state_t;
  state_t         state_q, state_d;
  logic [2:0]     lcnt_q, lcnt_d;
  logic [7:0]     wcnt_q, wcnt_d;
  logic           start_q, start_d;
  logic           out_valid_q, out_valid_d;
  logic           err_q, err_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   od_q, od_d;
  logic [7:0]     jobs_q, jobs_d;
  logic           timeout;
  // wcnt counts completed wait cycles, so the TIMEOUT-th unsatisfied cycle gives up
  assign timeout   = wcnt_q == 8'(TIMEOUT - 1);
  assign in_ready  = (state_q == IDLE) & dp_ready;
  assign start     = start_q;
  assign x_out     = x_q;
  assign out_valid = out_valid_q;
  assign out_data  = od_q;
  assign err       = err_q;
  assign jobs_done = jobs_q;
  always_comb begin
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    wcnt_d      = wcnt_q;
    start_d     = start_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    x_d         = x_q;
    od_d        = od_q;
    jobs_d      = jobs_q;
    case (state_q)
      IDLE: if (in_valid && dp_ready) begin
        state_d = LAUNCH;
        x_d     = in_data;
        start_d = 1'b1;
        lcnt_d  = '0;
      end
      LAUNCH: if (lcnt_q == 3'(START_LEN - 1)) begin
        state_d = WAIT_BUSY;
        start_d = 1'b0;
        wcnt_d  = '0;
      end else lcnt_d = lcnt_q + 3'd1;
      WAIT_BUSY: if (!dp_ready) begin
        state_d = WAIT_DONE;
        wcnt_d  = '0;
      end else if (timeout) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else wcnt_d = wcnt_q + 8'd1;
      WAIT_DONE: if (dp_ready) begin
        state_d     = HOLD;
        od_d        = dp_result;
        out_valid_d = 1'b1;
      end else if (timeout) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else wcnt_d = wcnt_q + 8'd1;
      HOLD: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        jobs_d      = jobs_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lcnt_q      <= '0;
      wcnt_q      <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      x_q         <= '0;
      od_q        <= '0;
      jobs_q      <= '0;
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      wcnt_q      <= wcnt_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      x_q         <= x_d;
      od_q        <= od_d;
      jobs_q      <= jobs_d;
    end
  end
endmodule

// File: tb/tb_series_job_sequencer.sv
// tb_series_job_sequencer: directed vector table, corner sequences and random traffic against a job-level reference model.
module tb_series_job_sequencer;
  localparam int W  = 16;
  localparam int SL = 2;
  localparam int TO = 255;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         start;
  logic [W-1:0] x_out;
  logic         dp_ready = 1'b1;
  logic [W-1:0] dp_result = '0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic         err;
  logic [7:0]   jobs_done;
  always #5 clk = ~clk;
  series_job_sequencer #(.W(W), .START_LEN(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .x_out(x_out), .dp_ready(dp_ready), .dp_result(dp_result),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .err(err), .jobs_done(jobs_done)
  );
  int total = 0;
  int bad = 0;
  // job-level model: one outstanding job with launch countdown, busy flag and wait budget
  bit           m_active, m_busy_seen, m_holding, m_err;
  int           m_start_left, m_waited, m_jobs;
  logic [W-1:0] m_x, m_od;
  typedef struct {
    logic iv; logic [15:0] id; logic dr; logic [15:0] res; logic ordy;
    logic e_ir; logic e_st; logic [15:0] e_x; logic e_ov; logic [15:0] e_od; logic [7:0] e_jobs;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic model_reset();
    m_active = 0; m_busy_seen = 0; m_holding = 0; m_err = 0;
    m_start_left = 0; m_waited = 0; m_jobs = 0; m_x = '0; m_od = '0;
  endtask
  task automatic model_check();
    chk("in_ready", 32'(in_ready), 32'(!m_active && dp_ready));
    chk("start", 32'(start), 32'(m_active && m_start_left > 0));
    chk("out_valid", 32'(out_valid), 32'(m_active && m_holding));
    chk("x_out", 32'(x_out), 32'(m_x));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("err", 32'(err), 32'(m_err));
    chk("jobs_done", 32'(jobs_done), 32'(m_jobs));
  endtask
  task automatic model_update(input logic iv, input logic [W-1:0] idt, input logic dr,
                              input logic [W-1:0] dres, input logic ordy);
    if (!m_active) begin
      if (iv && dr) begin
        m_active = 1; m_x = idt; m_start_left = SL; m_busy_seen = 0; m_holding = 0; m_waited = 0;
      end
    end else if (m_holding) begin
      if (ordy) begin
        m_holding = 0; m_active = 0; m_jobs = (m_jobs + 1) % 256;
      end
    end else if (m_start_left > 0) begin
      m_start_left -= 1;
    end else if (!m_busy_seen) begin
      if (!dr) begin
        m_busy_seen = 1; m_waited = 0;
      end else begin
        m_waited += 1;
        if (m_waited == TO) begin m_err = 1; m_active = 0; end
      end
    end else if (dr) begin
      m_holding = 1; m_od = dres;
    end else begin
      m_waited += 1;
      if (m_waited == TO) begin m_err = 1; m_active = 0; end
    end
  endtask
  task automatic step(input logic iv, input logic [W-1:0] idt, input logic dr,
                      input logic [W-1:0] dres, input logic ordy);
    in_valid = iv; in_data = idt; dp_ready = dr; dp_result = dres; out_ready = ordy;
    #1;
    model_check();
    @(posedge clk);
    model_update(iv, idt, dr, dres, ordy);
    @(negedge clk);
  endtask
  task automatic pulse_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_start", 32'(start), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_x_out", 32'(x_out), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_jobs", 32'(jobs_done), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(dp_ready));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic finish_job(input logic [W-1:0] res, input int hold);
    repeat (SL) step(1'b0, '0, 1'b1, '0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, res, 1'b0);
    for (int k = 0; k < hold; k++) begin
      step(1'b1, 16'hBEEF, 1'b1, ~res, 1'b0);
      chk("hold_out_valid", 32'(out_valid), 32'(1));
      chk("hold_out_data", 32'(out_data), 32'(res));
      chk("hold_in_ready", 32'(in_ready), 32'(0));
      chk("hold_jobs", 32'(jobs_done), 32'(m_jobs));
    end
    step(1'b0, '0, 1'b1, ~res, 1'b1);
    chk("xfer_out_valid", 32'(out_valid), 32'(0));
  endtask
  task automatic run_job(input logic [W-1:0] x, input logic [W-1:0] res, input int hold);
    step(1'b1, x, 1'b1, '0, 1'b0);
    finish_job(res, hold);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 16'h0003, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 16'h0000, 8'd0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 16'h0000, 8'd0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 16'h0000, 8'd0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 16'h0000, 8'd0};
    tbl[5]  = '{1'b1, 16'h0009, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 16'h0000, 8'd0};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 16'h0000, 8'd0};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 16'h0000, 8'd0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 16'h0014, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 16'h0000, 8'd0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 16'h0014, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 16'h0014, 8'd0};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 16'h0099, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 16'h0014, 8'd0};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0, 16'h0014, 8'd1};
    model_reset();
    @(negedge clk);
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].id; dp_ready = tbl[i].dr;
      dp_result = tbl[i].res; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("v%0d_start", i), 32'(start), 32'(tbl[i].e_st));
      chk($sformatf("v%0d_x_out", i), 32'(x_out), 32'(tbl[i].e_x));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
      chk($sformatf("v%0d_jobs", i), 32'(jobs_done), 32'(tbl[i].e_jobs));
      model_check();
      @(posedge clk);
      model_update(tbl[i].iv, tbl[i].id, tbl[i].dr, tbl[i].res, tbl[i].ordy);
      @(negedge clk);
    end
    repeat (4) begin
      step(1'b1, 16'h0055, 1'b0, '0, 1'b0);
      chk("busy_in_ready", 32'(in_ready), 32'(0));
      chk("busy_start", 32'(start), 32'(0));
    end
    step(1'b1, 16'h0055, 1'b1, '0, 1'b0);
    chk("busy_accept_start", 32'(start), 32'(1));
    chk("busy_accept_x", 32'(x_out), 32'(16'h0055));
    finish_job(16'h1234, 10);
    chk("bp_jobs", 32'(jobs_done), 32'(2));
    run_job(16'h0101, 16'h0202, 0);
    run_job(16'h0303, 16'h0404, 1);
    chk("b2b_jobs", 32'(jobs_done), 32'(4));
    step(1'b1, 16'h0077, 1'b1, '0, 1'b0);
    repeat (SL) step(1'b0, '0, 1'b1, '0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, '0, 1'b0);
    pulse_reset();
    step(1'b0, '0, 1'b1, 16'h5555, 1'b1);
    chk("post_rst_out_valid", 32'(out_valid), 32'(0));
    run_job(16'h0009, 16'h0021, 0);
    chk("post_rst_jobs", 32'(jobs_done), 32'(1));
    chk("post_rst_data", 32'(out_data), 32'(16'h0021));
    step(1'b1, 16'h000A, 1'b1, '0, 1'b0);
    repeat (SL) step(1'b0, '0, 1'b1, '0, 1'b0);
    repeat (TO - 1) step(1'b0, '0, 1'b1, '0, 1'b0);
    chk("tob_err_early", 32'(err), 32'(0));
    chk("tob_still_waiting", 32'(in_ready), 32'(0));
    step(1'b0, '0, 1'b1, '0, 1'b0);
    chk("tob_err", 32'(err), 32'(1));
    chk("tob_out_valid", 32'(out_valid), 32'(0));
    chk("tob_idle", 32'(in_ready), 32'(1));
    run_job(16'h000B, 16'h0002, 0);
    chk("tob_err_sticky", 32'(err), 32'(1));
    chk("tob_next_jobs", 32'(jobs_done), 32'(2));
    pulse_reset();
    step(1'b1, 16'h000C, 1'b1, '0, 1'b0);
    repeat (SL) step(1'b0, '0, 1'b1, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (TO - 1) step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("tod_err_early", 32'(err), 32'(0));
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("tod_err", 32'(err), 32'(1));
    chk("tod_out_valid", 32'(out_valid), 32'(0));
    step(1'b0, '0, 1'b1, '0, 1'b0);
    chk("tod_idle", 32'(in_ready), 32'(1));
    pulse_reset();
    for (int j = 0; j < 256; j++) begin
      run_job(16'(j), 16'(j * 3), 0);
      if (j == 254) chk("wrap_255", 32'(jobs_done), 32'(255));
    end
    chk("wrap_0", 32'(jobs_done), 32'(0));
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                16'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
